// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock timekeeping core.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN,
        SET_HR,
        SET_MIN,
        SET_AL_HR,
        SET_AL_MIN
    } state_t;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

    localparam logic [1:0] SETTING_RUN = 2'd0;
    localparam logic [1:0] SETTING_HR  = 2'd1;
    localparam logic [1:0] SETTING_MIN = 2'd2;
    localparam logic [1:0] SETTING_AL  = 2'd3;

    // Both alarm states collapse onto one externally visible code.
    function automatic logic [1:0] setting_of(state_t s);
        case (s)
            RUN:     return SETTING_RUN;
            SET_HR:  return SETTING_HR;
            SET_MIN: return SETTING_MIN;
            default: return SETTING_AL;
        endcase
    endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Prescaler dividing the system clock down to one event per CLK_FREQ enabled cycles.
module tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

    assign tick = en && (presc == LAST);

endmodule

// File: rtl/time_keeper.sv
// Timekeeping core: 1 Hz cascade of hour/minute/second counters plus button-driven set FSM.
// Optional alarm registers and output are built when TIME_KEEPER_ALARM_EN is defined.
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int WIDTH_HR  = 5,
    parameter int WIDTH_SEC = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_set,
    input  logic                 btn_inc,
    input  logic                 btn_mode,
    output logic                 mode,
    output logic [WIDTH_HR-1:0]  cntHr,
    output logic [WIDTH_SEC-1:0] cntMin,
    output logic [WIDTH_SEC-1:0] cntSec,
    output logic                 tick_1hz,
    output logic [1:0]           setting
`ifdef TIME_KEEPER_ALARM_EN
    ,
    output logic                 alarm_o,
    output logic [WIDTH_HR-1:0]  alHr,
    output logic [WIDTH_SEC-1:0] alMin
`endif
);

    localparam logic [WIDTH_HR-1:0]  HR_LAST  = WIDTH_HR'(HR_MAX);
    localparam logic [WIDTH_SEC-1:0] MIN_LAST = WIDTH_SEC'(MIN_MAX);
    localparam logic [WIDTH_SEC-1:0] SEC_LAST = WIDTH_SEC'(SEC_MAX);

    state_t state, state_n;

    logic                 run_st;
    logic                 sec_evt;
    logic                 enter_hr;
    logic                 inc_ok;
    logic                 sec_wrap;
    logic [WIDTH_HR-1:0]  hr_inc, nxt_hr;
    logic [WIDTH_SEC-1:0] min_inc, nxt_min, nxt_sec;

    assign run_st   = (state == RUN);
    assign enter_hr = run_st && btn_set;
    // btn_set takes priority; a coincident increment is discarded.
    assign inc_ok   = btn_inc && !btn_set;
    assign setting  = setting_of(state);

    tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_st),
        .clr   (enter_hr),
        .tick  (sec_evt)
    );

    always_comb begin
        hr_inc   = (cntHr  == HR_LAST)  ? '0 : cntHr + 1'b1;
        min_inc  = (cntMin == MIN_LAST) ? '0 : cntMin + 1'b1;
        sec_wrap = (cntSec == SEC_LAST);
        nxt_sec  = sec_wrap ? '0 : cntSec + 1'b1;
        nxt_min  = sec_wrap ? min_inc : cntMin;
        nxt_hr   = (sec_wrap && cntMin == MIN_LAST) ? hr_inc : cntHr;
    end

    always_comb begin
        state_n = state;
        if (btn_set) begin
            case (state)
                RUN:        state_n = SET_HR;
                SET_HR:     state_n = SET_MIN;
`ifdef TIME_KEEPER_ALARM_EN
                SET_MIN:    state_n = SET_AL_HR;
                SET_AL_HR:  state_n = SET_AL_MIN;
`else
                SET_MIN:    state_n = RUN;
`endif
                default:    state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode     <= 1'b1;
            tick_1hz <= 1'b0;
            cntHr    <= '0;
            cntMin   <= '0;
            cntSec   <= '0;
        end else begin
            mode     <= mode ^ btn_mode;
            tick_1hz <= sec_evt;
            if (sec_evt) begin
                cntSec <= nxt_sec;
                cntMin <= nxt_min;
                cntHr  <= nxt_hr;
            end
            // Entering hour-set restarts the second from zero.
            if (enter_hr) begin
                cntSec <= '0;
            end
            if (inc_ok && state == SET_HR) begin
                cntHr <= hr_inc;
            end
            if (inc_ok && state == SET_MIN) begin
                cntMin <= min_inc;
            end
        end
    end

`ifdef TIME_KEEPER_ALARM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_o <= 1'b0;
            alHr    <= '0;
            alMin   <= '0;
        end else begin
            if (inc_ok && state == SET_AL_HR) begin
                alHr <= (alHr == HR_LAST) ? '0 : alHr + 1'b1;
            end
            if (inc_ok && state == SET_AL_MIN) begin
                alMin <= (alMin == MIN_LAST) ? '0 : alMin + 1'b1;
            end
            // Match is judged on the time being written, so it fires at hh:mm:00.
            if (sec_evt && sec_wrap && nxt_min == alMin && nxt_hr == alHr) begin
                alarm_o <= 1'b1;
            end else if (inc_ok && run_st) begin
                alarm_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with a fast prescaler (CLK_FREQ = 4).
module tb_time_keeper;

    localparam int CF = 4;
    localparam int WH = 5;
    localparam int WS = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_set = 1'b0, btn_inc = 1'b0, btn_mode = 1'b0;
    logic          mode, tick_1hz;
    logic [WH-1:0] cntHr;
    logic [WS-1:0] cntMin, cntSec;
    logic [1:0]    setting;
`ifdef TIME_KEEPER_ALARM_EN
    logic          alarm_o;
    logic [WH-1:0] alHr;
    logic [WS-1:0] alMin;
`endif

    time_keeper #(.CLK_FREQ(CF), .WIDTH_HR(WH), .WIDTH_SEC(WS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_set  (btn_set),
        .btn_inc  (btn_inc),
        .btn_mode (btn_mode),
        .mode     (mode),
        .cntHr    (cntHr),
        .cntMin   (cntMin),
        .cntSec   (cntSec),
        .tick_1hz (tick_1hz),
        .setting  (setting)
`ifdef TIME_KEEPER_ALARM_EN
        ,
        .alarm_o  (alarm_o),
        .alHr     (alHr),
        .alMin    (alMin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s, i, m;
        int   hr, mn, sc, st, md, tk;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(logic s, logic i, logic m,
                                int hr, int mn, int sc, int st, int md, int tk);
        vec_t v;
        v.s = s; v.i = i; v.m = m;
        v.hr = hr; v.mn = mn; v.sc = sc; v.st = st; v.md = md; v.tk = tk;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, clock once, sample 1 time unit after the edge.
    task automatic step(input logic s, input logic i, input logic m);
        btn_set = s; btn_inc = i; btn_mode = m;
        @(posedge clk); #1;
        btn_set = 1'b0; btn_inc = 1'b0; btn_mode = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int k = 0; k < CF + 3; k++) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            if (tick_1hz) break;
        end
        if (!tick_1hz) chk("tick_timeout", 0, 1);
    endtask

    task automatic leave_min_set();
        step(1'b1, 1'b0, 1'b0);
`ifdef TIME_KEEPER_ALARM_EN
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        vec_t e;
        int   n;

        @(posedge clk); #1;
        do_reset();
        chk("rst_hr", int'(cntHr), 0);
        chk("rst_min", int'(cntMin), 0);
        chk("rst_sec", int'(cntSec), 0);
        chk("rst_tick", int'(tick_1hz), 0);
        chk("rst_setting", int'(setting), 0);
        chk("rst_mode", int'(mode), 1);
`ifdef TIME_KEEPER_ALARM_EN
        chk("rst_alarm", int'(alarm_o), 0);
`endif

        //  s  i  m   hr mn sc st md tk
        add(0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0,  0, 0, 1, 0, 1, 1);
        add(1, 1, 0,  0, 0, 0, 1, 1, 0);
        add(0, 1, 0,  1, 0, 0, 1, 1, 0);
        add(0, 0, 1,  1, 0, 0, 1, 0, 0);
        add(0, 1, 1,  2, 0, 0, 1, 1, 0);
        add(1, 0, 0,  2, 0, 0, 2, 1, 0);
        add(0, 1, 0,  2, 1, 0, 2, 1, 0);
`ifdef TIME_KEEPER_ALARM_EN
        add(1, 1, 0,  2, 1, 0, 3, 1, 0);
        add(1, 0, 0,  2, 1, 0, 3, 1, 0);
        add(1, 0, 0,  2, 1, 0, 0, 1, 0);
`else
        add(1, 1, 0,  2, 1, 0, 0, 1, 0);
`endif
        add(0, 0, 0,  2, 1, 0, 0, 1, 0);
        add(0, 1, 0,  2, 1, 0, 0, 1, 0);
        add(0, 0, 1,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0,  2, 1, 1, 0, 0, 1);

        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k]);
            step(vecs[k].s, vecs[k].i, vecs[k].m);
            e = exp_q.pop_front();
            n_vec++;
            if (cntHr != WH'(e.hr) || cntMin != WS'(e.mn) || cntSec != WS'(e.sc) ||
                setting != 2'(e.st) || mode != 1'(e.md) || tick_1hz != 1'(e.tk)) begin
                n_bad++;
                $display("FAIL vec%0d: got %0d:%0d:%0d set=%0d mode=%0d tick=%0d expected %0d:%0d:%0d set=%0d mode=%0d tick=%0d",
                         k, cntHr, cntMin, cntSec, setting, mode, tick_1hz,
                         e.hr, e.mn, e.sc, e.st, e.md, e.tk);
            end
        end

        // Day rollover: preload 23:59, count to 23:59:59, then one edge to 00:00:00.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (23) step(1'b0, 1'b1, 1'b0);
        chk("preload_hr", int'(cntHr), 23);
        step(1'b1, 1'b0, 1'b0);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        chk("preload_min", int'(cntMin), 59);
        leave_min_set();
        chk("preload_run", int'(setting), 0);
        wait_tick(n);
        chk("first_tick_gap", n, CF);
        repeat (57) wait_tick(n);
        chk("t58_sec", int'(cntSec), 58);
        wait_tick(n);
        chk("t59_time", int'(cntHr) * 10000 + int'(cntMin) * 100 + int'(cntSec), 235959);
        repeat (CF - 1) step(1'b0, 1'b0, 1'b0);
        chk("pre_wrap_time", int'(cntHr) * 10000 + int'(cntMin) * 100 + int'(cntSec), 235959);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_tick", int'(tick_1hz), 1);
        chk("wrap_time", int'(cntHr) * 10000 + int'(cntMin) * 100 + int'(cntSec), 0);

        // Field wrap while setting, and first tick after leaving the set states.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (25) step(1'b0, 1'b1, 1'b0);
        chk("hr_wrap25", int'(cntHr), 1);
        step(1'b1, 1'b0, 1'b0);
        repeat (61) step(1'b0, 1'b1, 1'b0);
        chk("min_wrap61", int'(cntMin), 1);
        leave_min_set();
        chk("exit_setting", int'(setting), 0);
        chk("exit_sec", int'(cntSec), 0);
        wait_tick(n);
        chk("exit_tick_gap", n, CF);
        chk("exit_tick_sec", int'(cntSec), 1);

        // Reset in the middle of minute setting.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1, 1'b0);
        chk("midset_min", int'(cntMin), 7);
        chk("midset_setting", int'(setting), 2);
        do_reset();
        chk("midrst_setting", int'(setting), 0);
        chk("midrst_time", int'(cntHr) + int'(cntMin) + int'(cntSec), 0);
        chk("midrst_mode", int'(mode), 1);

`ifdef TIME_KEEPER_ALARM_EN
        // Alarm at 00:01 fires on the 60th tick and holds until acknowledged in RUN.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("al_min", int'(alMin), 1);
        chk("al_hr", int'(alHr), 0);
        repeat (59) wait_tick(n);
        chk("al_before", int'(alarm_o), 0);
        wait_tick(n);
        chk("al_fire_time", int'(cntMin) * 100 + int'(cntSec), 100);
        chk("al_fire", int'(alarm_o), 1);
        repeat (2) wait_tick(n);
        chk("al_hold", int'(alarm_o), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("al_ack", int'(alarm_o), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
